ex_mem_stage: RTL

EX/MEM pipeline stage sitting directly downstream of the ALU. It latches the ALU result, store data and write-back control into the MEM stage. It freezes the front of the pipeline while a multi-cycle mul/div is in flight, and captures the one-cycle mul/div `ready` pulse into a hold buffer when MEM is stalled. It also registers the branch/jump redirect derived from the ALU's `is_zero` (branch-taken) flag.

---
 rtl/ex_mem_stage.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register. Tracks multi-cycle mul/div ops, parks a result that
// arrives while MEM is stalled in a one-entry hold buffer, and registers the PC redirect.
module ex_mem_stage #(
  parameter int XLEN     = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_valid,
  input  logic                ex_is_md,
  input  logic                ex_is_branch,
  input  logic                ex_is_jump,
  input  logic [XLEN-1:0]     alu_result,
  input  logic                alu_is_zero,
  input  logic                alu_ready,
  input  logic [XLEN-1:0]     ex_target,
  input  logic [XLEN-1:0]     ex_store_data,
  input  logic [REG_BITS-1:0] ex_rd,
  input  logic                ex_reg_write,
  input  logic                ex_mem_read,
  input  logic                ex_mem_write,
  input  logic                mem_stall,
  input  logic                flush,
  output logic                ex_stall,
  output logic                md_squash,
  output logic                mem_valid,
  output logic [XLEN-1:0]     mem_result,
  output logic [XLEN-1:0]     mem_store_data,
  output logic [REG_BITS-1:0] mem_rd,
  output logic                mem_reg_write,
  output logic                mem_mem_read,
  output logic                mem_mem_write,
  output logic                redirect,
  output logic [XLEN-1:0]     redirect_pc
);

  typedef struct packed {
    logic [XLEN-1:0]     result;
    logic [XLEN-1:0]     store_data;
    logic [REG_BITS-1:0] rd;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
  } mem_entry_t;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MD_BUSY = 2'd1;
  localparam logic [1:0] S_MD_HELD = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  mem_entry_t      r_mem;
  mem_entry_t      r_hold;
  mem_entry_t      w_ex_entry;
  logic            r_mem_valid;
  logic            r_redirect;
  logic [XLEN-1:0] r_redirect_pc;

  logic w_md_start;
  logic w_md_active;
  logic w_md_done;
  logic w_ex_latch;
  logic w_take_ex;
  logic w_take_hold;
  logic w_park;
  logic w_taken;

  assign w_ex_entry = {alu_result, ex_store_data, ex_rd,
                       ex_reg_write, ex_mem_read, ex_mem_write};

  // An md op is "active" in the cycle it is issued and every BUSY cycle after it,
  // so a ready pulse coinciding with issue completes without an extra state.
  assign w_md_start  = (r_state == S_IDLE) & ex_valid & ex_is_md & ~flush;
  assign w_md_active = w_md_start | ((r_state == S_MD_BUSY) & ~flush);
  assign w_md_done   = w_md_active & alu_ready;
  assign w_ex_latch  = (r_state == S_IDLE) & ex_valid & ~ex_is_md & ~flush;
  assign w_take_ex   = (w_ex_latch | w_md_done) & ~mem_stall;
  assign w_take_hold = (r_state == S_MD_HELD) & ~flush & ~mem_stall;
  assign w_park      = w_md_done & mem_stall;
  assign w_taken     = ex_valid & (ex_is_jump | (ex_is_branch & alu_is_zero));

  assign ex_stall  = rst_n & (mem_stall | (w_md_active & ~alu_ready));
  assign md_squash = rst_n & (r_state == S_MD_HELD);

  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_md_start) begin
          if (!alu_ready)    w_state_nxt = S_MD_BUSY;
          else if (mem_stall) w_state_nxt = S_MD_HELD;
        end
      end
      S_MD_BUSY: begin
        if (flush)          w_state_nxt = S_IDLE;
        else if (alu_ready) w_state_nxt = mem_stall ? S_MD_HELD : S_IDLE;
      end
      S_MD_HELD: begin
        if (flush || !mem_stall) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state       <= S_IDLE;
      r_mem         <= '0;
      r_hold        <= '0;
      r_mem_valid   <= 1'b0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_redirect <= 1'b0;
      if (w_park) r_hold <= w_ex_entry;
      if (w_take_hold) begin
        r_mem       <= r_hold;
        r_mem_valid <= 1'b1;
      end else if (w_take_ex) begin
        r_mem       <= w_ex_entry;
        r_mem_valid <= 1'b1;
        r_redirect  <= w_taken;
        if (ex_is_branch || ex_is_jump) r_redirect_pc <= ex_target;
      end else if (!mem_stall) begin
        // Bubble: data fields are don't-care, so only the qualifiers are cleared.
        r_mem_valid     <= 1'b0;
        r_mem.reg_write <= 1'b0;
        r_mem.mem_read  <= 1'b0;
        r_mem.mem_write <= 1'b0;
      end
    end
  end

  assign mem_valid      = r_mem_valid;
  assign mem_result     = r_mem.result;
  assign mem_store_data = r_mem.store_data;
  assign mem_rd         = r_mem.rd;
  assign mem_reg_write  = r_mem.reg_write;
  assign mem_mem_read   = r_mem.mem_read;
  assign mem_mem_write  = r_mem.mem_write;
  assign redirect       = r_redirect;
  assign redirect_pc    = r_redirect_pc;

endmodule
